// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared definitions for the iterative FP mantissa divider.
//   fdiv_state_t   - divider FSM states (IDLE, RUN, DONE)
//   fdiv_qw()      - quotient bit count for a given mantissa width
//   fdiv_res_t     - registered result bundle handed to the rounding stage;
//                    fields are sized for the widest supported format
//                    (double) and narrower formats use the low bits.
package fdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fdiv_state_t;

    localparam int unsigned FDIV_MANT_MAX_W = 53;
    localparam int unsigned FDIV_EXP_MAX_W  = 16;

    // One integer quotient bit, MANT_W-1 fraction bits, plus guard and
    // round-position bits for normalization.
    function automatic int unsigned fdiv_qw(input int unsigned mant_w);
        return mant_w + 2;
    endfunction

    typedef struct packed {
        logic                       sign;
        logic [FDIV_EXP_MAX_W-1:0]  exp;
        logic [FDIV_MANT_MAX_W-1:0] mant;
        logic                       guard;
        logic                       sticky;
        logic                       dz;
    } fdiv_res_t;

endpackage

// File: rtl/fdiv_iter_step.sv
// fdiv_iter_step: one combinational radix-2 restoring division step.
//   rem      - current partial remainder (W+1 bits, always < 2*div)
//   div      - divisor mantissa (W bits)
//   rem_next - next partial remainder, already shifted left by one
//   q_bit    - quotient bit produced by this step
module fdiv_iter_step #(
    parameter int unsigned W = 24
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] div,
    output logic [W:0]   rem_next,
    output logic         q_bit
);

    logic [W:0] diff;

    // Remainder stays below the divisor after each step, so the left shift
    // never loses a set bit out of the W+1-bit field.
    always_comb begin
        q_bit    = (rem >= {1'b0, div});
        diff     = rem - {1'b0, div};
        rem_next = (q_bit ? diff : rem) << 1;
    end

endmodule

// File: rtl/fdiv_mant_iter.sv
// fdiv_mant_iter: iterative radix-2 restoring mantissa divider for the FP
// divide pipeline. Computes Q = floor(A * 2^(MANT_W+1) / B) one bit per
// cycle, normalizes it, adjusts the exponent and produces guard/sticky.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid / in_ready      - operand handshake (in_ready only in IDLE)
//   sign_in, exp_in          - sign and pre-computed biased exponent
//   mant_a_in, mant_b_in     - dividend / divisor mantissas (B may be 0)
//   out_valid / out_ready    - result handshake (held until consumed)
//   sign_out, exp_out        - registered sign and adjusted exponent
//   mant_out                 - normalized quotient mantissa
//   guard_out, sticky_out    - rounding bits for the downstream stage
//   dz_out                   - divisor mantissa was zero
//
// Build option: define FDIV_EARLY_EXIT_EN to finish as soon as the partial
// remainder reaches zero; results are identical, only latency shrinks.
module fdiv_mant_iter
    import fdiv_pkg::*;
#(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_a_in,
    input  logic [MANT_W-1:0] mant_b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_out,
    output logic              guard_out,
    output logic              sticky_out,
    output logic              dz_out
);

    localparam int unsigned QW    = fdiv_qw(MANT_W);
    localparam int unsigned CNT_W = $clog2(QW);

    fdiv_state_t         state_q, state_d;
    logic [MANT_W:0]     rem_q, rem_d;
    logic [MANT_W-1:0]   div_q, div_d;
    logic [QW-2:0]       quo_q, quo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    fdiv_res_t           res_q, res_d;

    logic [MANT_W:0]     rem_step;
    logic                q_bit;
    logic [QW-1:0]       quo_next;
    logic [QW-1:0]       quo_fill;
    logic                last_step;
    logic [EXP_W-1:0]    exp_dec;
    logic [MANT_W-1:0]   mant_ones;
    fdiv_res_t           norm;

    fdiv_iter_step #(
        .W (MANT_W)
    ) u_step (
        .rem      (rem_q),
        .div      (div_q),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    // Quotient including this cycle's bit; quo_q only keeps the QW-1 bits
    // that still have to shift further.
    always_comb begin
        quo_next = {quo_q, q_bit};
`ifdef FDIV_EARLY_EXIT_EN
        // A zero remainder means every remaining quotient bit is 0: shift
        // the bits collected so far into their final positions.
        last_step = (cnt_q == '0) || (rem_step == '0);
        quo_fill  = quo_next << cnt_q;
`else
        last_step = (cnt_q == '0);
        quo_fill  = quo_next;
`endif
    end

    // Normalization of the finished quotient into the result bundle.
    always_comb begin
        exp_dec = exp_q - EXP_W'(1);
        norm      = '0;
        norm.sign = sign_q;
        if (quo_fill[QW-1]) begin
            norm.mant   = FDIV_MANT_MAX_W'(quo_fill[QW-1:2]);
            norm.guard  = quo_fill[1];
            norm.sticky = quo_fill[0] | (|rem_step);
            norm.exp    = FDIV_EXP_MAX_W'(exp_q);
        end else begin
            norm.mant   = FDIV_MANT_MAX_W'(quo_fill[QW-2:1]);
            norm.guard  = quo_fill[0];
            norm.sticky = |rem_step;
            norm.exp    = FDIV_EXP_MAX_W'(exp_dec);
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        div_d     = div_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        res_d     = res_q;
        mant_ones = '1;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    exp_d  = exp_in;
                    div_d  = mant_b_in;
                    if (mant_b_in == '0) begin
                        res_d      = '0;
                        res_d.sign = sign_in;
                        res_d.exp  = FDIV_EXP_MAX_W'(exp_in);
                        res_d.mant = FDIV_MANT_MAX_W'(mant_ones);
                        res_d.dz   = 1'b1;
                        state_d    = DONE;
                    end else begin
                        rem_d   = {1'b0, mant_a_in};
                        quo_d   = '0;
                        cnt_d   = CNT_W'(QW - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_step;
                quo_d = quo_next[QW-2:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step) begin
                    res_d   = norm;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign sign_out   = res_q.sign;
    assign exp_out    = res_q.exp[EXP_W-1:0];
    assign mant_out   = res_q.mant[MANT_W-1:0];
    assign guard_out  = res_q.guard;
    assign sticky_out = res_q.sticky;
    assign dz_out     = res_q.dz;

    // Result fields wider than this instance's format must stay zero.
    generate
        if (MANT_W < FDIV_MANT_MAX_W) begin : g_mant_pad
            always_ff @(posedge clk) begin
                if (!rst) assert (res_q.mant[FDIV_MANT_MAX_W-1:MANT_W] == '0);
            end
        end
        if (EXP_W < FDIV_EXP_MAX_W) begin : g_exp_pad
            always_ff @(posedge clk) begin
                if (!rst) assert (res_q.exp[FDIV_EXP_MAX_W-1:EXP_W] == '0);
            end
        end
    endgenerate

endmodule
